// File: rtl/gcdlcm_w_if.sv
// Request/result bundle for the iterative GCD/LCM engine.
// The master drives the operands and start; the slave returns busy, ready_n and result.
interface gcdlcm_w_if #(
    parameter int W = 32
);
    logic           start;
    logic           mode;
    logic [W-1:0]   ina;
    logic [W-1:0]   inb;
    logic           busy;
    logic           ready_n;
    logic [2*W-1:0] result;

    modport master (
        output start, mode, ina, inb,
        input  busy, ready_n, result
    );

    modport slave (
        input  start, mode, ina, inb,
        output busy, ready_n, result
    );
endinterface

// File: rtl/gcdlcm_w.sv
// Iterative GCD (binary, Stein) with an optional LCM = (a0 / g) * b0 tail.
// The tail is a restoring divide followed by a shift-add multiply, one bit per cycle.
module gcdlcm_w #(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    gcdlcm_w_if.slave  bus
);
    localparam int KW = $clog2(W + 1);
    localparam logic [KW-1:0] CNT_LAST = KW'(W - 1);

    typedef enum logic [2:0] {IDLE, GCD, DIV, MUL, DONE} state_t;

    state_t         state, state_n;
    logic [W-1:0]   a, b, a0, b0;
    logic [KW-1:0]  k, cnt;
    logic           mode_r;
    logic [2*W-1:0] result_r;

    logic [W-1:0]   g, q, r;
    logic [2*W-1:0] acc, mcand;

    logic           gcd_term, lcm_zero, r_ge, cnt_last;
    logic [W-1:0]   g_val, r_next, r_diff;
    logic [W:0]     r_sh;
    logic [2*W-1:0] acc_next;

    assign gcd_term = (a == '0) || (b == '0);
    assign g_val    = (a == '0) ? (b << k) : (a << k);
    assign lcm_zero = (g_val == '0) || (a0 == '0) || (b0 == '0);
    assign cnt_last = (cnt == CNT_LAST);

    // Restoring divide: bring in the next dividend bit, subtract g if it fits.
    // The true difference is below g, so the low W bits of the modular subtract are exact.
    assign r_sh     = {r, q[W-1]};
    assign r_ge     = (r_sh >= {1'b0, g});
    assign r_diff   = r_sh[W-1:0] - g;
    assign r_next   = r_ge ? r_diff : r_sh[W-1:0];
    assign acc_next = acc + (q[0] ? mcand : '0);

    assign bus.busy    = (state == GCD) || (state == DIV) || (state == MUL);
    assign bus.ready_n = (state != DONE);
    assign bus.result  = result_r;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (bus.start) state_n = GCD;
            GCD: if (gcd_term) state_n = (!mode_r || lcm_zero) ? DONE : DIV;
            DIV: if (cnt_last) state_n = MUL;
            MUL: if (cnt_last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            a0       <= '0;
            b0       <= '0;
            k        <= '0;
            cnt      <= '0;
            mode_r   <= 1'b0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a0     <= bus.ina;
                        b0     <= bus.inb;
                        mode_r <= bus.mode;
                        a      <= bus.ina;
                        b      <= bus.inb;
                        k      <= '0;
                    end
                end
                GCD: begin
                    if (gcd_term) begin
                        cnt <= '0;
                        if (!mode_r)       result_r <= {{W{1'b0}}, g_val};
                        else if (lcm_zero) result_r <= '0;
                    end else if (!a[0] && !b[0]) begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + KW'(1);
                    end else if (!a[0]) begin
                        a <= a >> 1;
                    end else if (!b[0]) begin
                        b <= b >> 1;
                    end else if (a >= b) begin
                        a <= (a - b) >> 1;
                    end else begin
                        b <= (b - a) >> 1;
                    end
                end
                DIV: cnt <= cnt_last ? '0 : cnt + KW'(1);
                MUL: begin
                    cnt <= cnt_last ? '0 : cnt + KW'(1);
                    if (cnt_last) result_r <= acc_next;
                end
                default: ;
            endcase
        end
    end

    // Divide/multiply datapath carries no reset; it is always initialised on entry to DIV/MUL.
    always_ff @(posedge clk) begin
        case (state)
            GCD: begin
                if (gcd_term) begin
                    g <= g_val;
                    q <= a0;
                    r <= '0;
                end
            end
            DIV: begin
                q <= {q[W-2:0], r_ge};
                r <= r_next;
                if (cnt_last) begin
                    acc   <= '0;
                    mcand <= {{W{1'b0}}, b0};
                end
            end
            MUL: begin
                acc   <= acc_next;
                mcand <= mcand << 1;
                q     <= q >> 1;
            end
            default: ;
        endcase
    end
endmodule
